piso_stream: RTL



---
 rtl/piso_stream_if.sv | 25 ++
 rtl/piso_stream.sv | 116 +++++++++++
 2 files changed

// File: rtl/piso_stream_if.sv
// rtl/piso_stream_if.sv - parallel-load and serial-output stream signals for piso_stream
interface piso_stream_if #(
  parameter int PE_NUM     = 8,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = $clog2(PE_NUM + 1)
);
  logic                             p_in_v;
  logic                             p_in_rdy;
  logic [PE_NUM*2*DATA_WIDTH-1:0]   p_in;
  logic [CNT_W-1:0]                 lane_cnt;
  logic                             s_out_v;
  logic                             s_out_rdy;
  logic [2*DATA_WIDTH-1:0]          s_out;
  logic                             s_out_last;

  modport master (
    output p_in_v, p_in, lane_cnt, s_out_rdy,
    input  p_in_rdy, s_out_v, s_out, s_out_last
  );

  modport slave (
    input  p_in_v, p_in, lane_cnt, s_out_rdy,
    output p_in_rdy, s_out_v, s_out, s_out_last
  );
endinterface

// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - frame-in / word-per-cycle-out converter with backpressure and end-of-frame
// Define PISO_STREAM_DBUF_EN to add a shadow frame register for gap-free back-to-back frames.
module piso_stream #(
  parameter int PE_NUM     = 8,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = $clog2(PE_NUM + 1)
) (
  input  logic        clk,
  input  logic        rst,
  piso_stream_if.slave bus
);
  localparam int WW = 2 * DATA_WIDTH;
  localparam int FW = PE_NUM * WW;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [FW-1:0]    frame;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] n;

  logic             load;
  logic             adv;
  logic             last_hs;
  logic             start;
  logic [FW-1:0]    start_frame;
  logic [CNT_W-1:0] start_n;
  logic [CNT_W-1:0] eff_cnt;
  logic [CNT_W:0]   k_plus2;

  assign load    = bus.p_in_v && bus.p_in_rdy;
  assign adv     = bus.s_out_v && bus.s_out_rdy;
  assign last_hs = adv && bus.s_out_last;
  assign k_plus2 = {1'b0, k} + (CNT_W+1)'(2);
  assign eff_cnt = (bus.lane_cnt == '0 || bus.lane_cnt > CNT_W'(PE_NUM)) ?
                   CNT_W'(PE_NUM) : bus.lane_cnt;

`ifdef PISO_STREAM_DBUF_EN
  logic             shadow_full;
  logic [FW-1:0]    shadow_frame;
  logic [CNT_W-1:0] shadow_n;
  logic             take_shadow;
  logic             shadow_cap;

  assign bus.p_in_rdy = !rst && !shadow_full;
  assign take_shadow  = last_hs && shadow_full;

  // A load coinciding with the last word of a frame and an empty shadow starts the
  // next frame directly instead of parking it in the shadow.
  always_comb begin
    start       = 1'b0;
    start_frame = bus.p_in;
    start_n     = eff_cnt;
    if (state == IDLE) begin
      start = load;
    end else if (last_hs) begin
      if (shadow_full) begin
        start       = 1'b1;
        start_frame = shadow_frame;
        start_n     = shadow_n;
      end else begin
        start = load;
      end
    end
  end

  assign shadow_cap = load && !(start && !take_shadow);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_full <= 1'b0;
    end else begin
      if (shadow_cap) begin
        shadow_frame <= bus.p_in;
        shadow_n     <= eff_cnt;
      end
      shadow_full <= shadow_cap | (shadow_full & ~take_shadow);
    end
  end
`else
  assign bus.p_in_rdy = !rst && (state == IDLE);
  assign start        = load;
  assign start_frame  = bus.p_in;
  assign start_n      = eff_cnt;
`endif

  // s_out holds the current word; frame holds the remaining lanes, shifted toward lane 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      frame          <= '0;
      k              <= '0;
      n              <= '0;
      bus.s_out_v    <= 1'b0;
      bus.s_out      <= '0;
      bus.s_out_last <= 1'b0;
    end else if (start) begin
      state          <= SHIFT;
      bus.s_out      <= start_frame[WW-1:0];
      frame          <= start_frame >> WW;
      k              <= '0;
      n              <= start_n;
      bus.s_out_v    <= 1'b1;
      bus.s_out_last <= (start_n == CNT_W'(1));
    end else if (last_hs) begin
      state          <= IDLE;
      bus.s_out_v    <= 1'b0;
      bus.s_out_last <= 1'b0;
    end else if (adv) begin
      bus.s_out      <= frame[WW-1:0];
      frame          <= frame >> WW;
      k              <= k + CNT_W'(1);
      bus.s_out_last <= (k_plus2 == {1'b0, n});
    end
  end
endmodule
